glcd_refresh_ctrl: RTL

- Parametrised refresh engine for KS0108-class segmented graphic LCDs (N column-controller chips, 8-pixel-tall pages).
- Owns an internal framebuffer that game logic (lanes, score digits, sprite) writes through a simple byte port.
- Sequences the LCD controller bus (E/RS/RW/CS/data) at a divided tick rate: power-up, display-on, then continuous or on-demand full-frame refresh.
- Generalises the fixed two-chip, free-running refresher with a chip count parameter, refresh modes, inversion, and frame-status handshakes.

---
 rtl/glcd_refresh_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/glcd_refresh_ctrl.sv
// glcd_refresh_ctrl: refresh engine for KS0108-class segmented graphic LCDs.
// Keeps a byte-wide framebuffer (one byte per page/column) written by game
// logic, and streams it to N column-controller chips over the parallel
// E/RS/RW/CS/data bus. Every bus transaction takes two divided ticks: the
// first drives RS/CS/data and raises E, the second drops E (the LCD latches
// on that falling edge).
module glcd_refresh_ctrl #(
  parameter int NUM_CHIPS     = 2,
  parameter int COLS_PER_CHIP = 64,
  parameter int PAGES         = 8,
  parameter int CLK_DIV       = 512,
  parameter int PWRUP_TICKS   = 16,
  parameter int COLW          = $clog2(NUM_CHIPS*COLS_PER_CHIP),
  parameter int PAGEW         = $clog2(PAGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [PAGEW-1:0]     wr_page,
  input  logic [COLW-1:0]      wr_col,
  input  logic [7:0]           wr_data,
  input  logic                 mode_oneshot,
  input  logic                 frame_req,
  input  logic                 invert,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 lcd_e,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_rst_n,
  output logic [NUM_CHIPS-1:0] lcd_cs,
  output logic [7:0]           lcd_data
);

  localparam int TOTAL_COLS = NUM_CHIPS*COLS_PER_CHIP;
  localparam int FB_DEPTH   = PAGES*TOTAL_COLS;
  localparam int ADDRW      = $clog2(FB_DEPTH);
  localparam int DIVW       = $clog2(CLK_DIV);
  localparam int PWRW       = (PWRUP_TICKS > 1) ? $clog2(PWRUP_TICKS) : 1;
  localparam int CCW        = (COLS_PER_CHIP > 1) ? $clog2(COLS_PER_CHIP) : 1;

  localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
  localparam logic [7:0] CMD_SET_COL    = 8'h40;

  localparam logic [NUM_CHIPS-1:0] ALL_CS    = {NUM_CHIPS{1'b1}};
  localparam logic [NUM_CHIPS-1:0] FIRST_CS  = NUM_CHIPS'(1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_DISP_ON,
    S_START_LINE,
    S_IDLE,
    S_SET_PAGE,
    S_SET_COL,
    S_DATA
  } state_t;

  state_t               state;
  logic                 phase;
  logic [DIVW-1:0]      div_cnt;
  logic                 tick;
  logic [PWRW-1:0]      pwr_cnt;
  logic [PAGEW-1:0]     page;
  logic [COLW-1:0]      col;
  logic [CCW-1:0]       chip_col;
  logic [NUM_CHIPS-1:0] cur_cs;

  logic [7:0]           fb_mem [FB_DEPTH];
  logic                 wr_ok;
  logic [ADDRW-1:0]     wr_addr;
  logic [ADDRW-1:0]     rd_addr;

  // The bus is write-only, so RW is tied low.
  assign lcd_rw = 1'b0;

  assign tick    = (div_cnt == DIVW'(CLK_DIV-1));
  assign wr_ok   = (int'(wr_page) < PAGES) && (int'(wr_col) < TOTAL_COLS);
  assign wr_addr = ADDRW'(int'(wr_page)*TOTAL_COLS + int'(wr_col));
  assign rd_addr = ADDRW'(int'(page)*TOTAL_COLS + int'(col));

  // Free-running bus tick divider: one-clk strobe every CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIVW'(1);
    end
  end

  // Framebuffer write port; survives reset and ignores out-of-range addresses.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      fb_mem[wr_addr] <= wr_data;
    end
  end

  // Bus sequencer: power-up, init commands, then page/column/data streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PWRUP;
      phase      <= 1'b0;
      pwr_cnt    <= '0;
      page       <= '0;
      col        <= '0;
      chip_col   <= '0;
      cur_cs     <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rst_n  <= 1'b0;
      lcd_cs     <= '0;
      lcd_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          S_PWRUP: begin
            if (pwr_cnt == PWRW'(PWRUP_TICKS-1)) begin
              lcd_rst_n <= 1'b1;
              phase     <= 1'b0;
              state     <= S_DISP_ON;
            end else begin
              pwr_cnt <= pwr_cnt + PWRW'(1);
            end
          end

          S_DISP_ON: begin
            if (!phase) begin
              lcd_rs   <= 1'b0;
              lcd_cs   <= ALL_CS;
              lcd_data <= CMD_DISP_ON;
              lcd_e    <= 1'b1;
              phase    <= 1'b1;
            end else begin
              lcd_e <= 1'b0;
              phase <= 1'b0;
              state <= S_START_LINE;
            end
          end

          S_START_LINE: begin
            if (!phase) begin
              lcd_rs   <= 1'b0;
              lcd_cs   <= ALL_CS;
              lcd_data <= CMD_START_LINE;
              lcd_e    <= 1'b1;
              phase    <= 1'b1;
            end else begin
              lcd_e <= 1'b0;
              phase <= 1'b0;
              state <= S_IDLE;
            end
          end

          S_IDLE: begin
            // The leaving tick is already the first half of the page command,
            // so continuous frames run back to back without a dead tick.
            if (!mode_oneshot || frame_req) begin
              busy     <= 1'b1;
              lcd_rs   <= 1'b0;
              lcd_cs   <= ALL_CS;
              lcd_data <= CMD_SET_PAGE + 8'(page);
              lcd_e    <= 1'b1;
              phase    <= 1'b1;
              state    <= S_SET_PAGE;
            end
          end

          S_SET_PAGE: begin
            if (!phase) begin
              lcd_rs   <= 1'b0;
              lcd_cs   <= ALL_CS;
              lcd_data <= CMD_SET_PAGE + 8'(page);
              lcd_e    <= 1'b1;
              phase    <= 1'b1;
            end else begin
              lcd_e <= 1'b0;
              phase <= 1'b0;
              state <= S_SET_COL;
            end
          end

          S_SET_COL: begin
            if (!phase) begin
              lcd_rs   <= 1'b0;
              lcd_cs   <= ALL_CS;
              lcd_data <= CMD_SET_COL;
              lcd_e    <= 1'b1;
              phase    <= 1'b1;
            end else begin
              lcd_e    <= 1'b0;
              phase    <= 1'b0;
              col      <= '0;
              chip_col <= '0;
              cur_cs   <= FIRST_CS;
              state    <= S_DATA;
            end
          end

          S_DATA: begin
            if (!phase) begin
              lcd_rs   <= 1'b1;
              lcd_cs   <= cur_cs;
              lcd_data <= fb_mem[rd_addr] ^ {8{invert}};
              lcd_e    <= 1'b1;
              phase    <= 1'b1;
            end else begin
              lcd_e <= 1'b0;
              phase <= 1'b0;
              if (col == COLW'(TOTAL_COLS-1)) begin
                if (page == PAGEW'(PAGES-1)) begin
                  page       <= '0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_IDLE;
                end else begin
                  page  <= page + PAGEW'(1);
                  state <= S_SET_PAGE;
                end
              end else begin
                col <= col + COLW'(1);
                if (chip_col == CCW'(COLS_PER_CHIP-1)) begin
                  chip_col <= '0;
                  cur_cs   <= cur_cs << 1;
                end else begin
                  chip_col <= chip_col + CCW'(1);
                end
              end
            end
          end

          default: begin
            state <= S_PWRUP;
          end
        endcase
      end
    end
  end

endmodule
